// File: rtl/mdu_iter_if.sv
// mdu_iter_if
//   Request/response bundle for the iterative multiply/divide unit.
//   slave  : the unit itself (mdu_iter)
//   master : the execute-stage controller (or a testbench)
//   Signals
//     flush_i  abort any operation in flight
//     valid_i  request valid            ready_o  unit can accept a request
//     ctrl_i   {w, funct3}              op1_i / op2_i  operands
//     valid_o  result valid             ready_i  consumer accepts result
//     out_o    result                   busy_o   unit not idle
interface mdu_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [3:0]            ctrl_i;
  logic [DATA_WIDTH-1:0] op1_i;
  logic [DATA_WIDTH-1:0] op2_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] out_o;
  logic                  busy_o;

  modport slave (
    input  flush_i, valid_i, ctrl_i, op1_i, op2_i, ready_i,
    output ready_o, valid_o, out_o, busy_o
  );

  modport master (
    output flush_i, valid_i, ctrl_i, op1_i, op2_i, ready_i,
    input  ready_o, valid_o, out_o, busy_o
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter
//   Iterative RV32M/RV64M multiply/divide unit. A radix-2 shift-add
//   multiplier and a restoring divider share one 2*DATA_WIDTH accumulator.
//   Operands are converted to magnitudes on accept; the result sign is
//   applied on the last iteration.
//   Ports
//     clk_i   system clock
//     rstn_i  asynchronous active-low reset
//     bus     mdu_iter_if.slave (request, result and flush handshakes)
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  mdu_iter_if.slave bus
);
  localparam int W = DATA_WIDTH;

  if (W != 32 && W != 64) begin : g_bad_width
    $error("mdu_iter: DATA_WIDTH must be 32 or 64");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [W-1:0] LO32_MASK = W'(64'h0000_0000_FFFF_FFFF);
  localparam logic [W-1:0] MIN_W     = {1'b1, {(W-1){1'b0}}};

  logic [1:0]     state_q,  state_d;
  logic [6:0]     cnt_q,    cnt_d;
  logic [2*W-1:0] acc_q,    acc_d;
  logic [W-1:0]   b_q,      b_d;
  logic [2:0]     funct3_q, funct3_d;
  logic           word_q,   word_d;
  logic           neg_q,    neg_d;
  logic           rneg_q,   rneg_d;
  logic           short_q,  short_d;
  logic [W-1:0]   out_q,    out_d;

  // Request decode on the live inputs; only used in the accepting cycle.
  logic [2:0]   req_f3;
  logic         req_w, req_is_div, req_illegal, req_short;
  logic         req_a_signed, req_b_signed;
  logic         a_neg, b_neg, a_min, b_m1, div_zero, div_ovf;
  logic [W-1:0] a_ext, b_ext, a_mag, b_mag, div_lo, short_res;

  always_comb begin
    req_f3      = bus.ctrl_i[2:0];
    req_w       = bus.ctrl_i[3];
    req_is_div  = req_f3[2];
    req_illegal = req_w && ((W == 32) || (!req_is_div && (req_f3 != 3'b000)));

    if (req_is_div) begin
      req_a_signed = !req_f3[0];
      req_b_signed = !req_f3[0];
    end else begin
      req_a_signed = (req_f3 == 3'b001) || (req_f3 == 3'b010);
      req_b_signed = (req_f3 == 3'b001);
    end

    // Word ops see the sign-extended low half; magnitudes are then trimmed
    // back to 32 bits so the iteration works on a 32-bit quantity.
    a_ext = req_w ? W'($signed(bus.op1_i[31:0])) : bus.op1_i;
    b_ext = req_w ? W'($signed(bus.op2_i[31:0])) : bus.op2_i;
    a_neg = req_a_signed && (req_w ? bus.op1_i[31] : bus.op1_i[W-1]);
    b_neg = req_b_signed && (req_w ? bus.op2_i[31] : bus.op2_i[W-1]);
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    if (req_w) begin
      a_mag = a_mag & LO32_MASK;
      b_mag = b_mag & LO32_MASK;
    end

    a_min    = req_w ? (bus.op1_i[31:0] == 32'h8000_0000) : (bus.op1_i == MIN_W);
    b_m1     = req_w ? (bus.op2_i[31:0] == 32'hFFFF_FFFF) : (&bus.op2_i);
    div_zero = req_is_div && (b_mag == '0);
    div_ovf  = req_is_div && !req_f3[0] && a_min && b_m1;
    req_short = req_illegal || div_zero || div_ovf;

    short_res = '0;
    if (req_illegal) begin
      short_res = '0;
    end else if (div_zero) begin
      short_res = req_f3[1] ? a_ext : '1;
    end else if (div_ovf) begin
      short_res = req_f3[1] ? '0 : a_ext;
    end

    // A word dividend is parked in the upper half of the quotient register
    // so its bits reach the remainder within 32 shifts.
    div_lo = req_w ? (a_mag << (W - 32)) : a_mag;
  end

  // One iteration of the shared datapath plus the final sign fix-up.
  logic [W:0]     mul_sum;
  logic [W:0]     div_diff;
  logic           div_ok;
  logic [2*W-1:0] acc_step, acc_fix;
  logic [W-1:0]   q_fix, r_fix, div_sel, res_final;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_diff = acc_q[2*W-1:W-1] - {1'b0, b_q};
    // Shifted remainder with its top bit set already exceeds any divisor.
    div_ok   = acc_q[2*W-1] || !div_diff[W];

    if (funct3_q[2]) begin
      if (div_ok) acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      else        acc_step = {acc_q[2*W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end

    acc_fix = neg_q  ? -acc_step : acc_step;
    q_fix   = neg_q  ? -acc_step[W-1:0]   : acc_step[W-1:0];
    r_fix   = rneg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
    div_sel = funct3_q[1] ? r_fix : q_fix;

    // A word product ends up scaled by 2^32, so its low word is [63:32].
    if (funct3_q[2]) begin
      res_final = word_q ? W'($signed(div_sel[31:0])) : div_sel;
    end else if (word_q) begin
      res_final = W'($signed(acc_fix[63:32]));
    end else if (funct3_q == 3'b000) begin
      res_final = acc_fix[W-1:0];
    end else begin
      res_final = acc_fix[2*W-1:W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    funct3_d = funct3_q;
    word_d   = word_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    short_d  = short_q;
    out_d    = out_q;

    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            funct3_d = req_f3;
            word_d   = req_w;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            short_d  = req_short;
            b_d      = req_is_div ? b_mag : a_mag;
            // Short-path result waits in the accumulator for one CALC cycle
            // so out_o only changes on entry to DONE.
            if (req_short)       acc_d = {{W{1'b0}}, short_res};
            else if (req_is_div) acc_d = {{W{1'b0}}, div_lo};
            else                 acc_d = {{W{1'b0}}, b_mag};
            if (req_short)                  cnt_d = 7'd1;
            else if (req_w || (W == 32))    cnt_d = 7'd32;
            else                            cnt_d = 7'd64;
            state_d = CALC;
          end
        end
        CALC: begin
          if (short_q) begin
            out_d = acc_q[W-1:0];
          end else begin
            acc_d = acc_step;
            if (cnt_q == 7'd1) out_d = res_final;
          end
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = DONE;
        end
        DONE: begin
          if (bus.ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      funct3_q <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      short_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      funct3_q <= funct3_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      short_q  <= short_d;
      out_q    <= out_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.out_o   = out_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter
//   Directed bench for mdu_iter: one RV32 and one RV64 instance share the
//   clock and reset. Table-driven vectors plus hand-written sequences for
//   result back-pressure, flush and asynchronous reset.
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mdu_iter_if #(.DATA_WIDTH(32)) bus32 ();
  mdu_iter_if #(.DATA_WIDTH(64)) bus64 ();

  mdu_iter #(.DATA_WIDTH(32)) dut32 (.clk_i(clk), .rstn_i(rstn), .bus(bus32.slave));
  mdu_iter #(.DATA_WIDTH(64)) dut64 (.clk_i(clk), .rstn_i(rstn), .bus(bus64.slave));

  typedef struct {
    string       name;
    bit          rv64;
    logic [3:0]  ctrl;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] expected;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input bit rv64, input logic v, input logic [3:0] ctrl,
                          input logic [63:0] a, input logic [63:0] b);
    if (rv64) begin
      bus64.valid_i = v;
      bus64.ctrl_i  = ctrl;
      bus64.op1_i   = a;
      bus64.op2_i   = b;
    end else begin
      bus32.valid_i = v;
      bus32.ctrl_i  = ctrl;
      bus32.op1_i   = a[31:0];
      bus32.op2_i   = b[31:0];
    end
  endtask

  function automatic logic readyOf(input bit rv64);
    return rv64 ? bus64.ready_o : bus32.ready_o;
  endfunction

  function automatic logic validOf(input bit rv64);
    return rv64 ? bus64.valid_o : bus32.valid_o;
  endfunction

  function automatic logic [63:0] outOf(input bit rv64);
    return rv64 ? bus64.out_o : {32'h0, bus32.out_o};
  endfunction

  // Waits for ready_o, presents one request, returns just after the accept
  // edge with the inputs scrambled so latching is exercised.
  task automatic startOp(input bit rv64, input logic [3:0] ctrl,
                         input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!readyOf(rv64) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    driveReq(rv64, 1'b1, ctrl, a, b);
    @(posedge clk);
    #1;
    driveReq(rv64, 1'b0, ~ctrl, ~a, ~b);
  endtask

  // Runs one operation; lat counts edges from accept until valid_o is seen.
  task automatic applyStimulus(input bit rv64, input logic [3:0] ctrl,
                               input logic [63:0] a, input logic [63:0] b,
                               output logic [63:0] res, output int lat);
    startOp(rv64, ctrl, a, b);
    lat = 0;
    while (!validOf(rv64) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = outOf(rv64);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] res;
    int          lat;
    int          seen;

    rstn = 1'b0;
    bus32.flush_i = 1'b0; bus32.ready_i = 1'b1;
    bus64.flush_i = 1'b0; bus64.ready_i = 1'b1;
    driveReq(1'b0, 1'b0, 4'h0, 64'h0, 64'h0);
    driveReq(1'b1, 1'b0, 4'h0, 64'h0, 64'h0);

    #12;
    checkOutput("reset ready32", 64'(bus32.ready_o), 64'd1);
    checkOutput("reset valid32", 64'(bus32.valid_o), 64'd0);
    checkOutput("reset busy32",  64'(bus32.busy_o),  64'd0);
    checkOutput("reset out32",   64'(bus32.out_o),   64'd0);
    checkOutput("reset ready64", 64'(bus64.ready_o), 64'd1);
    checkOutput("reset valid64", 64'(bus64.valid_o), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // RV32 vectors
    vecs.push_back('{"mul_neg",      0, 4'h0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 32});
    vecs.push_back('{"mulh_min",     0, 4'h1, 64'h80000000, 64'h80000000, 64'h40000000, 32});
    vecs.push_back('{"mulhu_max",    0, 4'h3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 32});
    vecs.push_back('{"mulhsu_max",   0, 4'h2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 32});
    vecs.push_back('{"mulh_mixed",   0, 4'h1, 64'hFFFFFFFD, 64'h5,        64'hFFFFFFFF, 32});
    vecs.push_back('{"mul_lo",       0, 4'h0, 64'h12345678, 64'h10,       64'h23456780, 32});
    vecs.push_back('{"div_ovf",      0, 4'h4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1});
    vecs.push_back('{"rem_ovf",      0, 4'h6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        1});
    vecs.push_back('{"divu_zero",    0, 4'h5, 64'h5,        64'h0,        64'hFFFFFFFF, 1});
    vecs.push_back('{"remu_zero",    0, 4'h7, 64'h5,        64'h0,        64'h5,        1});
    vecs.push_back('{"div_zero_s",   0, 4'h4, 64'hFFFFFFFB, 64'h0,        64'hFFFFFFFF, 1});
    vecs.push_back('{"rem_zero_s",   0, 4'h6, 64'hFFFFFFFB, 64'h0,        64'hFFFFFFFB, 1});
    vecs.push_back('{"div_neg",      0, 4'h4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 32});
    vecs.push_back('{"rem_neg",      0, 4'h6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 32});
    vecs.push_back('{"div_pos",      0, 4'h4, 64'h64,       64'h7,        64'hE,        32});
    vecs.push_back('{"rem_negdivsr", 0, 4'h6, 64'h64,       64'hFFFFFFF9, 64'h2,        32});
    vecs.push_back('{"divu_big",     0, 4'h5, 64'hFFFFFFFF, 64'h10,       64'h0FFFFFFF, 32});
    vecs.push_back('{"remu_big",     0, 4'h7, 64'hFFFFFFFF, 64'h10,       64'hF,        32});
    vecs.push_back('{"w_on_rv32",    0, 4'h8, 64'h3,        64'h4,        64'h0,        1});
    // RV64 vectors
    vecs.push_back('{"divw_neg",     1, 4'hC, 64'h00000000FFFFFFF8, 64'h2, 64'hFFFFFFFFFFFFFFFC, 32});
    vecs.push_back('{"mulw_wrap",    1, 4'h8, 64'h7FFFFFFF, 64'h2, 64'hFFFFFFFFFFFFFFFE, 32});
    vecs.push_back('{"mul64",        1, 4'h0, 64'h0000000100000003, 64'h5, 64'h000000050000000F, 64});
    vecs.push_back('{"mulhu64",      1, 4'h3, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h1, 64});
    vecs.push_back('{"div64_neg",    1, 4'h4, 64'hFFFFFFFFFFFFFF9C, 64'h7, 64'hFFFFFFFFFFFFFFF2, 64});
    vecs.push_back('{"remuw",        1, 4'hF, 64'h1234567800000007, 64'hAAAAAAAA00000002, 64'h1, 32});
    vecs.push_back('{"divuw_zero",   1, 4'hD, 64'h0000000080000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF, 1});
    vecs.push_back('{"remw_zero",    1, 4'hE, 64'h0000000080000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000000, 1});
    vecs.push_back('{"divw_ovf",     1, 4'hC, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1});
    vecs.push_back('{"mulhw_illeg",  1, 4'h9, 64'h5, 64'h6, 64'h0, 1});
    vecs.push_back('{"divw_garbage", 1, 4'hC, 64'hDEADBEEF00000064, 64'h12345678FFFFFFF9, 64'hFFFFFFFFFFFFFFF2, 32});
    vecs.push_back('{"remw_garbage", 1, 4'hE, 64'hDEADBEEF00000064, 64'h12345678FFFFFFF9, 64'h2, 32});
    vecs.push_back('{"div64_ovf",    1, 4'h4, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1});
    vecs.push_back('{"rem64_neg",    1, 4'h6, 64'hFFFFFFFFFFFFFF9C, 64'h7, 64'hFFFFFFFFFFFFFFFE, 64});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rv64, vecs[i].ctrl, vecs[i].op1, vecs[i].op2, res, lat);
      checkOutput({vecs[i].name, " result"}, res, vecs[i].expected);
      checkOutput({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure: result held while ready_i is low.
    @(negedge clk);
    @(negedge clk);
    bus32.ready_i = 1'b0;
    applyStimulus(1'b0, 4'h4, 64'hFFFFFFF9, 64'h2, res, lat);
    checkOutput("hold div result", res, 64'hFFFFFFFD);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("hold out stable", 64'(bus32.out_o), 64'hFFFFFFFD);
      checkOutput("hold ready_o low", 64'(bus32.ready_o), 64'd0);
      checkOutput("hold valid_o high", 64'(bus32.valid_o), 64'd1);
    end
    @(negedge clk);
    bus32.ready_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release ready_o", 64'(bus32.ready_o), 64'd1);
    checkOutput("release valid_o", 64'(bus32.valid_o), 64'd0);
    checkOutput("release busy_o",  64'(bus32.busy_o),  64'd0);

    // Flush in the 10th CALC cycle, with a competing request that must be ignored.
    startOp(1'b0, 4'h0, 64'h7, 64'h3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus32.flush_i = 1'b1;
    driveReq(1'b0, 1'b1, 4'h5, 64'h9, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("flush busy_o",  64'(bus32.busy_o),  64'd0);
    checkOutput("flush ready_o", 64'(bus32.ready_o), 64'd1);
    checkOutput("flush valid_o", 64'(bus32.valid_o), 64'd0);
    bus32.flush_i = 1'b0;
    driveReq(1'b0, 1'b0, 4'h0, 64'h0, 64'h0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus32.valid_o || bus32.busy_o) seen++;
    end
    checkOutput("flush no activity", 64'(seen), 64'd0);
    applyStimulus(1'b0, 4'h3, 64'h12345678, 64'h10, res, lat);
    checkOutput("post-flush result", res, 64'h1);
    checkOutput("post-flush latency", 64'(lat), 64'd32);

    // Asynchronous reset in the middle of a 64-bit divide.
    startOp(1'b1, 4'h4, 64'hFFFFFFFFFFFFFF9C, 64'h7);
    repeat (5) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("async rst ready64", 64'(bus64.ready_o), 64'd1);
    checkOutput("async rst valid64", 64'(bus64.valid_o), 64'd0);
    checkOutput("async rst busy64",  64'(bus64.busy_o),  64'd0);
    checkOutput("async rst out64",   bus64.out_o,        64'd0);
    checkOutput("async rst out32",   64'(bus32.out_o),   64'd0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b1, 4'h3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, res, lat);
    checkOutput("post-reset mulhu64", res, 64'hFFFFFFFFFFFFFFFE);
    checkOutput("post-reset latency", 64'(lat), 64'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
